// File: rtl/div_share_ctrl_if.sv
// Request/response bundle between the compute units and the shared-divider scheduler.
// Handshakes: a transfer happens on a rising edge where valid & ready are both high; a producer
// holds valid and its payload stable until that edge, and ready may depend combinationally on valid.
interface div_share_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int N_REQ  = 4,
  parameter int ID_W   = $clog2(N_REQ)
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        req_sign;
  logic [N_REQ*DATA_W-1:0] req_dividend;
  logic [N_REQ*DATA_W-1:0] req_divisor;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [DATA_W-1:0]       rsp_quotient;
  logic [DATA_W-1:0]       rsp_remainder;
  logic                    rsp_dbz;
  logic                    busy;

  modport master (
    output req_valid, req_sign, req_dividend, req_divisor, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, busy
  );

  modport slave (
    input  req_valid, req_sign, req_dividend, req_divisor, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, busy
  );
endinterface

// File: rtl/div_share_ctrl.sv
// Round-robin scheduler sharing one serial shift-subtract divider among N_REQ requesters,
// with the divider itself (div_subshift) defined alongside.
module div_subshift #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sign,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);
  localparam int PC_W = $clog2(DATA_W + 2);
  localparam logic [PC_W-1:0] PC_DONE = PC_W'(DATA_W + 1);

  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] quo, rem, dvs;
  logic              neg_q, neg_r;
  logic [DATA_W:0]   shifted, diff;
  logic              a_neg, b_neg;

  assign a_neg   = sign & dividend[DATA_W-1];
  assign b_neg   = sign & divisor[DATA_W-1];
  assign shifted = {rem, quo[DATA_W-1]};
  assign diff    = shifted - {1'b0, dvs};

  // pc 0 loads magnitudes, pc 1..DATA_W run one restoring step each, PC_DONE holds the result.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      pc    <= '0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (pc == '0) begin
      quo   <= a_neg ? -dividend : dividend;
      dvs   <= b_neg ? -divisor : divisor;
      rem   <= '0;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      pc    <= pc + 1'b1;
    end else if (pc != PC_DONE) begin
      rem <= diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
      quo <= {quo[DATA_W-2:0], ~diff[DATA_W]};
      pc  <= pc + 1'b1;
    end
  end

  assign done      = (pc == PC_DONE);
  assign quotient  = neg_q ? -quo : quo;
  assign remainder = neg_r ? -rem : rem;
endmodule

module div_share_ctrl #(
  parameter int DATA_W = 32,
  parameter int N_REQ  = 4,
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  div_share_ctrl_if.slave   bus,
  output logic [1:0]        state_dbg
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state;
  logic [ID_W-1:0]   last_grant;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_idx;
  logic              found;
  int                cand;
  logic [DATA_W-1:0] dvd_arr [N_REQ];
  logic [DATA_W-1:0] dvs_arr [N_REQ];
  logic [DATA_W-1:0] sel_dividend, sel_divisor;
  logic              sel_sign;

  logic              op_sign;
  logic [DATA_W-1:0] op_a, op_b;
  logic [ID_W-1:0]   rsp_id_q;
  logic [DATA_W-1:0] rsp_q_q, rsp_r_q;
  logic              rsp_dbz_q;

  logic              div_en, div_done;
  logic [DATA_W-1:0] div_q, div_r;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign dvd_arr[g] = bus.req_dividend[g*DATA_W +: DATA_W];
    assign dvs_arr[g] = bus.req_divisor[g*DATA_W +: DATA_W];
  end

  // Search starts one past the previous winner so every requester is reached within N_REQ grants.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(last_grant) + 1 + k) % N_REQ;
      for (int j = 0; j < N_REQ; j++) begin
        if (!found && (j == cand) && bus.req_valid[j]) begin
          found     = 1'b1;
          grant[j]  = 1'b1;
          grant_idx = ID_W'(j);
        end
      end
    end
  end

  assign sel_dividend = dvd_arr[grant_idx];
  assign sel_divisor  = dvs_arr[grant_idx];
  assign sel_sign     = bus.req_sign[grant_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= ID_W'(N_REQ - 1);
      op_sign    <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      rsp_id_q   <= '0;
      rsp_q_q    <= '0;
      rsp_r_q    <= '0;
      rsp_dbz_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            last_grant <= grant_idx;
            rsp_id_q   <= grant_idx;
            op_sign    <= sel_sign;
            op_a       <= sel_dividend;
            op_b       <= sel_divisor;
            if (sel_divisor == '0) begin
              // Divide-by-zero never touches the divider; the raw dividend is returned.
              rsp_q_q   <= '1;
              rsp_r_q   <= sel_dividend;
              rsp_dbz_q <= 1'b1;
              state     <= S_RESP;
            end else begin
              rsp_dbz_q <= 1'b0;
              state     <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (div_done) begin
            rsp_q_q <= div_q;
            rsp_r_q <= div_r;
            state   <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // en stays up through RESP so the divider keeps its result; dropping it in IDLE clears it.
  assign div_en = !rst && ((state == S_RUN) || ((state == S_RESP) && !rsp_dbz_q));

  div_subshift #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .en        (div_en),
    .sign      (op_sign),
    .dividend  (op_a),
    .divisor   (op_b),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  assign bus.req_ready     = (!rst && (state == S_IDLE)) ? grant : '0;
  assign bus.rsp_valid     = (state == S_RESP);
  assign bus.rsp_id        = rsp_id_q;
  assign bus.rsp_quotient  = rsp_q_q;
  assign bus.rsp_remainder = rsp_r_q;
  assign bus.rsp_dbz       = rsp_dbz_q;
  assign bus.busy          = (state != S_IDLE);
  assign state_dbg         = state;
endmodule

// File: tb/tb_div_share_ctrl.sv
// Bench for div_share_ctrl: per-requester operand lists feed the request ports, an expected
// queue holds reference results in predicted grant order, responses are popped and compared.
`timescale 1ns/1ps
module tb_div_share_ctrl;
  localparam int DATA_W = 32;
  localparam int N_REQ  = 4;
  localparam int ID_W   = 2;
  localparam int EW     = ID_W + 2*DATA_W + 1;
  localparam int MAX_OPS = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  div_share_ctrl_if #(.DATA_W(DATA_W), .N_REQ(N_REQ), .ID_W(ID_W)) bus ();

  div_share_ctrl #(.DATA_W(DATA_W), .N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [EW-1:0] model(input int id, input logic s,
                                          input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0]        q, r;
    logic signed [DATA_W-1:0] sa, sb;
    sa = a;
    sb = b;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (s && (a == {1'b1, {(DATA_W-1){1'b0}}}) && (b == '1)) begin
      q = a;
      r = '0;
    end else if (s) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {ID_W'(id), q, r, (b == '0)};
  endfunction

  // Scoreboard state
  logic [EW-1:0] exp_q[$];
  int            acc_q[$];

  // Per-requester operand lists
  logic              op_s [N_REQ][MAX_OPS];
  logic [DATA_W-1:0] op_a [N_REQ][MAX_OPS];
  logic [DATA_W-1:0] op_b [N_REQ][MAX_OPS];
  int                n_ops [N_REQ] = '{default: 0};
  int                nxt   [N_REQ] = '{default: 0};

  task automatic add_op(input int i, input logic s, input logic [DATA_W-1:0] a,
                        input logic [DATA_W-1:0] b, input bit expect_rsp);
    op_s[i][n_ops[i]] = s;
    op_a[i][n_ops[i]] = a;
    op_b[i][n_ops[i]] = b;
    n_ops[i]++;
    acc_q.push_back(i);
    if (expect_rsp) exp_q.push_back(model(i, s, a, b));
  endtask

  // Requester driver: presents each requester's next operand set, advancing on acceptance.
  logic [N_REQ-1:0] drv_acc;
  initial begin
    bus.req_valid    = '0;
    bus.req_sign     = '0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    forever begin
      @(negedge clk);
      drv_acc = rst ? '0 : (bus.req_valid & bus.req_ready);
      @(posedge clk);
      #1;
      for (int i = 0; i < N_REQ; i++) begin
        if (drv_acc[i]) nxt[i]++;
        if (nxt[i] < n_ops[i]) begin
          bus.req_valid[i] = 1'b1;
          bus.req_sign[i]  = op_s[i][nxt[i]];
          bus.req_dividend[i*DATA_W +: DATA_W] = op_a[i][nxt[i]];
          bus.req_divisor[i*DATA_W +: DATA_W]  = op_b[i][nxt[i]];
        end else begin
          bus.req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: grant order, response contents, latency and handshake spacing.
  int            acc_count = 0, last_acc_cyc = 0, last_hs_cyc = 0, acc_gap = 0, last_lat = 0;
  int            mon_id, mon_exp_id;
  logic [EW-1:0] mon_exp;
  logic          prev_rsp_valid = 1'b0, en_seen = 1'b0, rsp_seen = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_rsp_valid = 1'b0;
    end else begin
      if (dut.div_en) en_seen = 1'b1;
      if (bus.rsp_valid) rsp_seen = 1'b1;
      if (|(bus.req_valid & bus.req_ready)) begin
        mon_id = 0;
        for (int i = 0; i < N_REQ; i++) if (bus.req_ready[i]) mon_id = i;
        check_eq("grant_onehot", $countones(bus.req_ready), 1);
        mon_exp_id = (acc_q.size() != 0) ? acc_q.pop_front() : -1;
        check_eq("grant_id", mon_id, mon_exp_id);
        acc_gap      = cyc - last_hs_cyc;
        last_acc_cyc = cyc;
        acc_count++;
      end
      if (bus.rsp_valid && !prev_rsp_valid) last_lat = cyc - last_acc_cyc;
      prev_rsp_valid = bus.rsp_valid;
      if (bus.rsp_valid && bus.rsp_ready) begin
        last_hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          check_eq("rsp_unexpected", exp_q.size(), 1);
        end else begin
          mon_exp = exp_q.pop_front();
          check_eq("rsp_id", bus.rsp_id, mon_exp[EW-1 -: ID_W]);
          check_eq("rsp_quotient", bus.rsp_quotient, mon_exp[2*DATA_W -: DATA_W]);
          check_eq("rsp_remainder", bus.rsp_remainder, mon_exp[DATA_W -: DATA_W]);
          check_eq("rsp_dbz", bus.rsp_dbz, mon_exp[0]);
        end
      end
    end
  end

  task automatic do_reset();
    for (int i = 0; i < N_REQ; i++) begin
      n_ops[i] = 0;
      nxt[i]   = 0;
    end
    exp_q.delete();
    acc_q.delete();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (((exp_q.size() != 0) || (acc_q.size() != 0)) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, exp_q.size() + acc_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int a0;
    bus.rsp_ready = 1'b1;
    rst = 1'b1;

    // Reset values while rst is held
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rsp_valid", bus.rsp_valid, 0);
    check_eq("rst_rsp_id", bus.rsp_id, 0);
    check_eq("rst_rsp_quotient", bus.rsp_quotient, 0);
    check_eq("rst_rsp_remainder", bus.rsp_remainder, 0);
    check_eq("rst_rsp_dbz", bus.rsp_dbz, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_req_ready", bus.req_ready, 0);
    check_eq("rst_state", state_dbg, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Unsigned 100/7 from requester 2
    add_op(2, 1'b0, 32'd100, 32'd7, 1'b1);
    wait_drain("t1_drain", 100);
    check_eq("t1_latency", last_lat, DATA_W + 3);

    // Signed cases, including min / -1
    add_op(0, 1'b1, 32'hFFFF_FF9C, 32'd7, 1'b1);
    wait_drain("t2a_drain", 100);
    add_op(1, 1'b1, 32'd100, 32'hFFFF_FFF9, 1'b1);
    wait_drain("t2b_drain", 100);
    add_op(3, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_drain("t2c_drain", 100);

    // Divide by zero bypasses the divider
    do_reset();
    en_seen = 1'b0;
    add_op(1, 1'b0, 32'h1234, 32'd0, 1'b1);
    wait_drain("t3_drain", 20);
    check_eq("t3_latency", last_lat, 1);
    check_eq("t3_en_seen", en_seen, 0);

    // All four requesters continuously valid
    do_reset();
    add_op(0, 1'b0, 32'd1000, 32'd10, 1'b1);
    add_op(1, 1'b1, 32'hFFFF_FC18, 32'd33, 1'b1);
    add_op(2, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b1);
    add_op(3, 1'b0, 32'hFFFF_FFFF, 32'd3, 1'b1);
    add_op(0, 1'b1, 32'd77, 32'hFFFF_FFFB, 1'b1);
    add_op(1, 1'b0, 32'd5, 32'd9, 1'b1);
    wait_drain("t4_drain", 400);
    check_eq("t4_gap", acc_gap, 1);

    // Random operands, two rounds over all requesters
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N_REQ; i++) begin
        add_op(i, 1'($urandom_range(0, 1)), $urandom,
               ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 28)), 1'b1);
      end
    end
    wait_drain("t5_drain", 600);

    // Response back-pressure: fields stable, no grants, next accept right after handshake
    do_reset();
    bus.rsp_ready = 1'b0;
    add_op(0, 1'b0, 32'd500, 32'd7, 1'b1);
    add_op(1, 1'b0, 32'd81, 32'd4, 1'b1);
    n = 0;
    while (!bus.rsp_valid && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6_rsp_up", bus.rsp_valid, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_eq("t6_hold_valid", bus.rsp_valid, 1);
      check_eq("t6_hold_id", bus.rsp_id, 0);
      check_eq("t6_hold_q", bus.rsp_quotient, 71);
      check_eq("t6_hold_r", bus.rsp_remainder, 3);
      check_eq("t6_hold_busy", bus.busy, 1);
      check_eq("t6_hold_ready", bus.req_ready, 0);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    wait_drain("t6_drain", 100);
    check_eq("t6_gap", acc_gap, 1);

    // Reset in the middle of RUN discards the operation
    do_reset();
    a0 = acc_count;
    add_op(3, 1'b0, 32'd1000, 32'd3, 1'b0);
    n = 0;
    while ((acc_count == a0) && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    check_eq("t7_accepted", acc_count, a0 + 1);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rsp_seen = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("t7_no_rsp", rsp_seen, 0);
    check_eq("t7_busy", bus.busy, 0);
    @(posedge clk);
    #1;
    add_op(0, 1'b0, 32'd81, 32'd9, 1'b1);
    wait_drain("t7_drain", 100);
    check_eq("t7_latency", last_lat, DATA_W + 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish (checks=%0d)", n_checks);
    $fatal(1, "watchdog");
  end
endmodule
